// File: rtl/red_zone_tracker_pkg.sv
// red_track_pkg: shared constants and types for the red-pixel zone tracker.
//   H_ACT/V_ACT     default active frame size
//   ZONE_W/ZONE_H   zone size for a 4x4 grid
//   N_ZONES         number of zones
//   zone_acc_t      per-zone working set (bounding box + saturating count)
//   mid10()         box-centre helper (11-bit sum, >>1, 10-bit result)
package red_track_pkg;

    localparam int unsigned H_ACT   = 640;
    localparam int unsigned V_ACT   = 480;
    localparam int unsigned ZONE_W  = H_ACT / 4;
    localparam int unsigned ZONE_H  = V_ACT / 4;
    localparam int unsigned N_ZONES = 16;

    localparam logic [9:0]  IDLE_MIN = 10'h3FF;
    localparam logic [9:0]  IDLE_MAX = 10'h000;
    localparam logic [14:0] CNT_MAX  = '1;

    typedef struct packed {
        logic [9:0]  xmin;
        logic [9:0]  xmax;
        logic [9:0]  ymin;
        logic [9:0]  ymax;
        logic [14:0] cnt;
    } zone_acc_t;

    localparam zone_acc_t ZONE_IDLE = '{
        xmin: IDLE_MIN,
        xmax: IDLE_MAX,
        ymin: IDLE_MIN,
        ymax: IDLE_MAX,
        cnt:  15'd0
    };

    function automatic logic [9:0] mid10(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[10:1];
    endfunction

endpackage

// File: rtl/red_zone_tracker_if.sv
// red_zone_tracker_if: pixel stream in, published per-zone target data out.
//   pix_valid/x_pixel/y_pixel/is_red   classifier sample stream
//   aim_x_all/aim_y_all                per-zone box centre
//   aim_detected_all                   per-zone detected flag
//   box_*_all                          per-zone box corners (12 b, zero-extended)
//   frame_update                       one-cycle pulse when outputs change
// master: stream source / output consumer; slave: the tracker.
interface red_zone_tracker_if;
    import red_track_pkg::*;

    logic                          pix_valid;
    logic [9:0]                    x_pixel;
    logic [9:0]                    y_pixel;
    logic                          is_red;

    logic [N_ZONES-1:0][9:0]       aim_x_all;
    logic [N_ZONES-1:0][9:0]       aim_y_all;
    logic [N_ZONES-1:0]            aim_detected_all;
    logic [N_ZONES-1:0][11:0]      box_x_min_all;
    logic [N_ZONES-1:0][11:0]      box_x_max_all;
    logic [N_ZONES-1:0][11:0]      box_y_min_all;
    logic [N_ZONES-1:0][11:0]      box_y_max_all;
    logic                          frame_update;

    modport master (
        output pix_valid, x_pixel, y_pixel, is_red,
        input  aim_x_all, aim_y_all, aim_detected_all,
               box_x_min_all, box_x_max_all, box_y_min_all, box_y_max_all,
               frame_update
    );

    modport slave (
        input  pix_valid, x_pixel, y_pixel, is_red,
        output aim_x_all, aim_y_all, aim_detected_all,
               box_x_min_all, box_x_max_all, box_y_min_all, box_y_max_all,
               frame_update
    );

endinterface

// File: rtl/red_zone_tracker_zone_index.sv
// zone_index: combinational pixel-to-zone mapping for a 4x4 grid.
//   x_i, y_i   pixel coordinates
//   valid_o    coordinate lies inside the active area
//   k_o        zone index row*4+col (0 = top-left, 15 = bottom-right)
// Column/row come from threshold compares, no division.
module zone_index #(
    parameter int unsigned H_ACT = 640,
    parameter int unsigned V_ACT = 480
) (
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    output logic       valid_o,
    output logic [3:0] k_o
);
    import red_track_pkg::*;

    localparam int unsigned ZW = H_ACT / 4;
    localparam int unsigned ZH = V_ACT / 4;

    logic [1:0] col;
    logic [1:0] row;

    always_comb begin
        col = 2'd0;
        if (32'(x_i) >= 3 * ZW)      col = 2'd3;
        else if (32'(x_i) >= 2 * ZW) col = 2'd2;
        else if (32'(x_i) >= ZW)     col = 2'd1;

        row = 2'd0;
        if (32'(y_i) >= 3 * ZH)      row = 2'd3;
        else if (32'(y_i) >= 2 * ZH) row = 2'd2;
        else if (32'(y_i) >= ZH)     row = 2'd1;

        valid_o = (32'(x_i) < H_ACT) && (32'(y_i) < V_ACT);
        k_o     = {row, col};
    end

endmodule

// File: rtl/red_zone_tracker.sv
// red_zone_tracker: accumulates a bounding box and count of red pixels per
// zone (4x4 grid) over a frame, and publishes box, aim point and detected flag
// for all zones atomically after the last active pixel.
//   clk       pixel clock
//   reset_n   asynchronous active-low reset
//   bus       red_zone_tracker_if.slave (sample stream in, zone data out)
// Pipeline: stage 1 registers sample + zone index, stage 2 does a single-zone
// read-modify-write, and one cycle later the publish/clear happens.
module red_zone_tracker import red_track_pkg::*; #(
    parameter int unsigned H_ACT      = 640,
    parameter int unsigned V_ACT      = 480,
    parameter int unsigned MIN_PIXELS = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    red_zone_tracker_if.slave   bus
);

    // ---------------- Stage 1: filter, zone lookup, register ----------------
    logic       zi_valid;
    logic [3:0] zi_k;

    zone_index #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT)
    ) u_zone_index (
        .x_i     (bus.x_pixel),
        .y_i     (bus.y_pixel),
        .valid_o (zi_valid),
        .k_o     (zi_k)
    );

    logic       s1_valid_d, s1_last_d;
    logic       s1_valid_q, s1_red_q, s1_last_q;
    logic [9:0] s1_x_q, s1_y_q;
    logic [3:0] s1_k_q;

    always_comb begin
        s1_valid_d = bus.pix_valid && zi_valid;
        s1_last_d  = (bus.x_pixel == 10'(H_ACT - 1)) && (bus.y_pixel == 10'(V_ACT - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_red_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_k_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_red_q   <= bus.is_red;
            s1_last_q  <= s1_last_d;
            s1_x_q     <= bus.x_pixel;
            s1_y_q     <= bus.y_pixel;
            s1_k_q     <= zi_k;
        end
    end

    // ---------------- Stage 2: working-set update ----------------
    zone_acc_t ws_q [N_ZONES];
    zone_acc_t upd_d;
    logic      s2_last_q;

    always_comb begin
        upd_d = ws_q[s1_k_q];
        if (s1_x_q < upd_d.xmin) upd_d.xmin = s1_x_q;
        if (s1_x_q > upd_d.xmax) upd_d.xmax = s1_x_q;
        if (s1_y_q < upd_d.ymin) upd_d.ymin = s1_y_q;
        if (s1_y_q > upd_d.ymax) upd_d.ymax = s1_y_q;
        if (upd_d.cnt != CNT_MAX) upd_d.cnt = upd_d.cnt + 15'd1;
    end

    // The clear on publish cannot collide with a pixel write because upstream
    // guarantees idle cycles after the last pixel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < N_ZONES; k++) ws_q[k] <= ZONE_IDLE;
            s2_last_q <= 1'b0;
        end else begin
            s2_last_q <= s1_valid_q && s1_last_q;
            if (s2_last_q) begin
                for (int unsigned k = 0; k < N_ZONES; k++) ws_q[k] <= ZONE_IDLE;
            end else if (s1_valid_q && s1_red_q) begin
                ws_q[s1_k_q] <= upd_d;
            end
        end
    end

    // ---------------- Publish ----------------
    logic [N_ZONES-1:0]       det_d;
    logic [N_ZONES-1:0]       det_q;
    logic [N_ZONES-1:0][9:0]  bxmin_q, bxmax_q, bymin_q, bymax_q;
    logic [N_ZONES-1:0][9:0]  aimx_q, aimy_q;
    logic                     frame_update_q;

    always_comb begin
        det_d = '0;
        for (int unsigned k = 0; k < N_ZONES; k++) begin
            det_d[k] = 32'(ws_q[k].cnt) >= MIN_PIXELS;
        end
    end

    // Undetected zones keep their previous box/aim; only the flag drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            det_q          <= '0;
            bxmin_q        <= '0;
            bxmax_q        <= '0;
            bymin_q        <= '0;
            bymax_q        <= '0;
            aimx_q         <= '0;
            aimy_q         <= '0;
            frame_update_q <= 1'b0;
        end else begin
            frame_update_q <= s2_last_q;
            if (s2_last_q) begin
                det_q <= det_d;
                for (int unsigned k = 0; k < N_ZONES; k++) begin
                    if (det_d[k]) begin
                        bxmin_q[k] <= ws_q[k].xmin;
                        bxmax_q[k] <= ws_q[k].xmax;
                        bymin_q[k] <= ws_q[k].ymin;
                        bymax_q[k] <= ws_q[k].ymax;
                        aimx_q[k]  <= mid10(ws_q[k].xmin, ws_q[k].xmax);
                        aimy_q[k]  <= mid10(ws_q[k].ymin, ws_q[k].ymax);
                    end
                end
            end
        end
    end

    always_comb begin
        bus.aim_x_all        = aimx_q;
        bus.aim_y_all        = aimy_q;
        bus.aim_detected_all = det_q;
        bus.frame_update     = frame_update_q;
        for (int unsigned k = 0; k < N_ZONES; k++) begin
            bus.box_x_min_all[k] = {2'b00, bxmin_q[k]};
            bus.box_x_max_all[k] = {2'b00, bxmax_q[k]};
            bus.box_y_min_all[k] = {2'b00, bymin_q[k]};
            bus.box_y_max_all[k] = {2'b00, bymax_q[k]};
        end
    end

endmodule

// File: tb/tb_red_zone_tracker.sv
// tb_red_zone_tracker: directed bench for red_zone_tracker. Two instances share
// one stimulus stream: dut_a with MIN_PIXELS=1, dut_b with MIN_PIXELS=64.
module tb_red_zone_tracker;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    red_zone_tracker_if if_a ();
    red_zone_tracker_if if_b ();

    red_zone_tracker #(.H_ACT(640), .V_ACT(480), .MIN_PIXELS(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(if_a)
    );
    red_zone_tracker #(.H_ACT(640), .V_ACT(480), .MIN_PIXELS(64)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(if_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        pv;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        red;
        logic [15:0] mask;   // expected dut_a flags after the one-pixel frame
        int          k;      // zone whose box is checked, -1 for none
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [9:0] x, input logic [9:0] y, input logic r);
        if_a.pix_valid = v; if_a.x_pixel = x; if_a.y_pixel = y; if_a.is_red = r;
        if_b.pix_valid = v; if_b.x_pixel = x; if_b.y_pixel = y; if_b.is_red = r;
    endtask

    task automatic drive(input logic v, input logic [9:0] x, input logic [9:0] y, input logic r);
        @(negedge clk);
        set_in(v, x, y, r);
    endtask

    // Sends the last active pixel and checks frame_update is high exactly on
    // the third negedge after it was presented.
    task automatic end_frame(input string tag);
        drive(1'b1, 10'd639, 10'd479, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check({tag, "_fu_a"}, 32'(if_a.frame_update), 32'(i == 3));
            check({tag, "_fu_b"}, 32'(if_b.frame_update), 32'(i == 3));
            set_in(1'b0, 10'd0, 10'd0, 1'b0);
        end
    endtask

    task automatic check_zone(input string tag, input int sel, input int k,
                              input int xmin, input int xmax, input int ymin, input int ymax,
                              input int ax, input int ay);
        logic [11:0] a, b, c, d;
        logic [9:0]  px, py;
        if (sel == 0) begin
            a = if_a.box_x_min_all[k]; b = if_a.box_x_max_all[k];
            c = if_a.box_y_min_all[k]; d = if_a.box_y_max_all[k];
            px = if_a.aim_x_all[k];    py = if_a.aim_y_all[k];
        end else begin
            a = if_b.box_x_min_all[k]; b = if_b.box_x_max_all[k];
            c = if_b.box_y_min_all[k]; d = if_b.box_y_max_all[k];
            px = if_b.aim_x_all[k];    py = if_b.aim_y_all[k];
        end
        check({tag, "_xmin"}, 32'(a), 32'(xmin));
        check({tag, "_xmax"}, 32'(b), 32'(xmax));
        check({tag, "_ymin"}, 32'(c), 32'(ymin));
        check({tag, "_ymax"}, 32'(d), 32'(ymax));
        check({tag, "_aimx"}, 32'(px), 32'(ax));
        check({tag, "_aimy"}, 32'(py), 32'(ay));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_nz"}, 32'(|{if_a.aim_x_all, if_a.aim_y_all, if_a.aim_detected_all,
                                    if_a.box_x_min_all, if_a.box_x_max_all,
                                    if_a.box_y_min_all, if_a.box_y_max_all, if_a.frame_update}), 32'd0);
        check({tag, "_b_nz"}, 32'(|{if_b.aim_x_all, if_b.aim_y_all, if_b.aim_detected_all,
                                    if_b.box_x_min_all, if_b.box_x_max_all,
                                    if_b.box_y_min_all, if_b.box_y_max_all, if_b.frame_update}), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 10'd200, 10'd130, 1'b1, 16'h0020,  5};
        vecs[1] = '{1'b1, 10'd159, 10'd0,   1'b1, 16'h0001,  0};
        vecs[2] = '{1'b1, 10'd160, 10'd0,   1'b1, 16'h0002,  1};
        vecs[3] = '{1'b1, 10'd0,   10'd119, 1'b1, 16'h0001,  0};
        vecs[4] = '{1'b1, 10'd0,   10'd120, 1'b1, 16'h0010,  4};
        vecs[5] = '{1'b1, 10'd700, 10'd10,  1'b1, 16'h0000, -1};
        vecs[6] = '{1'b0, 10'd200, 10'd130, 1'b1, 16'h0000, -1};
        vecs[7] = '{1'b1, 10'd10,  10'd480, 1'b1, 16'h0000, -1};
        vecs[8] = '{1'b1, 10'd10,  10'd10,  1'b0, 16'h0000, -1};
        vecs[9] = '{1'b1, 10'd639, 10'd0,   1'b1, 16'h0008,  3};

        // Reset state
        reset_n = 1'b0;
        set_in(1'b0, 10'd0, 10'd0, 1'b0);
        repeat (3) @(negedge clk);
        check_all_zero("rst_hold");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("rst_rel");

        // One-pixel frames: zone mapping, boundaries and filtering
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].pv, vecs[i].x, vecs[i].y, vecs[i].red);
            end_frame($sformatf("v%0d", i));
            check($sformatf("v%0d_det_a", i), 32'(if_a.aim_detected_all), 32'(vecs[i].mask));
            check($sformatf("v%0d_det_b", i), 32'(if_b.aim_detected_all), 32'd0);
            if (vecs[i].k >= 0)
                check_zone($sformatf("v%0d_z", i), 0, vecs[i].k,
                           int'(vecs[i].x), int'(vecs[i].x), int'(vecs[i].y), int'(vecs[i].y),
                           int'(vecs[i].x), int'(vecs[i].y));
        end

        // Rectangle x 10..29, y 20..39 (400 back-to-back red pixels in zone 0)
        for (int y = 20; y <= 39; y++)
            for (int x = 10; x <= 29; x++)
                drive(1'b1, 10'(x), 10'(y), 1'b1);
        end_frame("rect");
        check("rect_det_b", 32'(if_b.aim_detected_all), 32'h0001);
        check("rect_det_a", 32'(if_a.aim_detected_all), 32'h0001);
        check_zone("rect_b", 1, 0, 10, 29, 20, 39, 19, 29);
        check_zone("rect_a", 0, 0, 10, 29, 20, 39, 19, 29);

        // Empty frame: flags drop, boxes hold
        drive(1'b1, 10'd50, 10'd50, 1'b0);
        end_frame("empty");
        check("empty_det_b", 32'(if_b.aim_detected_all), 32'h0000);
        check("empty_det_a", 32'(if_a.aim_detected_all), 32'h0000);
        check_zone("empty_b", 1, 0, 10, 29, 20, 39, 19, 29);

        // 63 pixels in zone 15: below threshold for dut_b
        for (int i = 0; i < 63; i++) drive(1'b1, 10'(480 + i), 10'd400, 1'b1);
        end_frame("z15_63");
        check("z15_63_det_b", 32'(if_b.aim_detected_all), 32'h0000);
        check_zone("z15_63_b", 1, 15, 0, 0, 0, 0, 0, 0);
        check("z15_63_det_a", 32'(if_a.aim_detected_all), 32'h8000);
        check_zone("z15_63_a", 0, 15, 480, 542, 400, 400, 511, 400);

        // 64 pixels in zone 15: at threshold; aim sum exceeds 10 bits
        for (int y = 470; y <= 471; y++)
            for (int x = 608; x <= 639; x++)
                drive(1'b1, 10'(x), 10'(y), 1'b1);
        end_frame("z15_64");
        check("z15_64_det_b", 32'(if_b.aim_detected_all), 32'h8000);
        check_zone("z15_64_b", 1, 15, 608, 639, 470, 471, 623, 470);
        check_zone("z15_64_a", 0, 15, 608, 639, 470, 471, 623, 470);

        // Mid-frame reset after 100 red pixels in zone 3
        for (int i = 0; i < 100; i++) drive(1'b1, 10'(480 + i), 10'd10, 1'b1);
        @(negedge clk);
        set_in(1'b0, 10'd0, 10'd0, 1'b0);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("mid_rst");
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b1, 10'(500 + i), 10'd50, 1'b1);
        end_frame("post_rst");
        check("post_rst_det_a", 32'(if_a.aim_detected_all), 32'h0008);
        check_zone("post_rst_a", 0, 3, 500, 504, 50, 50, 502, 50);
        check("post_rst_det_b", 32'(if_b.aim_detected_all), 32'h0000);
        check_zone("post_rst_b", 1, 3, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/red_zone_tracker.md
# red_zone_tracker

Produces the per-zone target data that the overlay mixer draws. It sits between the red-pixel classifier and the overlay path, and scans each active frame pixel by pixel. The frame is split into a 4×4 grid of 16 zones, and the block accumulates a bounding box and pixel count for red pixels in each zone. At end of frame it publishes, as one atomic update, the box corners, box-centre aim points and detected flags for all zones.

## Interface
Parameters:
- H_ACT, 640: active pixels per line
- V_ACT, 480: active lines per frame
- MIN_PIXELS, 64: red-pixel count at or above which a zone is "detected"

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- pix_valid  in  1  x_pixel/y_pixel/is_red are a valid active-area sample
- x_pixel  in  10  column of current sample
- y_pixel  in  10  line of current sample
- is_red  in  1  classifier says this pixel is red
- aim_x_all  out  16×10  per-zone aim x, (box_x_min+box_x_max)>>1
- aim_y_all  out  16×10  per-zone aim y, (box_y_min+box_y_max)>>1
- aim_detected_all  out  16  per-zone detected flag
- box_x_min_all, box_x_max_all, box_y_min_all, box_y_max_all  out  16×12 each  per-zone box corners, zero-extended from 10 bits
- frame_update  out  1  one-cycle pulse on the cycle the outputs take new values

## Operation
- Zone geometry:
  - ZONE_W = H_ACT/4 = 160 and ZONE_H = V_ACT/4 = 120.
  - col = x/160 and row = y/120, each found by threshold compares. No dividers.
  - Zone index k = row*4 + col, so k=0 is top-left and k=15 is bottom-right.
- Sample filtering: a sample is dropped if pix_valid=0, x_pixel ≥ H_ACT or y_pixel ≥ V_ACT.
- Working set per zone: wxmin, wxmax, wymin, wymax (10 b each) and wcnt (15 b, saturating at 32767).
  - Idle (cleared) values: wxmin = wymin = 10'h3FF, wxmax = wymax = 0, wcnt = 0.
- Per-pixel update: each red sample that passes filtering updates its zone.
  - wxmin = min(wxmin, x), wxmax = max(wxmax, x), wymin = min(wymin, y), wymax = max(wymax, y).
  - wcnt increments.
  - Only one zone is written per cycle.
- Frame end: detected when a filtered sample has x = H_ACT-1 and y = V_ACT-1. That sample is processed, then the publish step runs.
- Publish step, for all k at once:
  - detected[k] = (wcnt[k] ≥ MIN_PIXELS).
  - Box and aim outputs load from the working set only where detected[k] = 1. Where detected[k] = 0 they hold their previous values, and only the flag drops.
  - Aim uses an 11-bit sum, shifted right by 1, truncated to 10 bits.
  - On the same edge all working sets clear to their idle values.
- Non-red samples never change the working sets.

## Timing
- Two-stage pipeline:
  - Stage 1 registers x, y, red and the zone index.
  - Stage 2 writes the working set.
- If the last pixel is sampled in cycle N:
  - Edge N+1: stage 1 holds it.
  - Edge N+2: its working-set update lands.
  - Edge N+3: outputs update and working sets clear.
  - frame_update is high for exactly the cycle following edge N+3.
- Upstream guarantees at least 3 cycles with pix_valid=0 after the last pixel; VGA blanking satisfies this. Behaviour when this is violated is undefined.
- Outputs are stable between publish edges, so the mixer may read them at any time.
- Reset (reset_n low, at any time including mid-frame):
  - All outputs go to 0 and frame_update to 0.
  - Working sets go to their idle values and the pipeline valid bits are cleared.
  - The first publish after reset covers only pixels seen after reset was released.
- Back-to-back red pixels in the same zone must accumulate correctly. Stage 2 performs a read-modify-write of a single zone each cycle, so no forwarding hazard exists.

## Structure
- Package red_track_pkg holds:
  - H_ACT, V_ACT, ZONE_W, ZONE_H, N_ZONES = 16 and the idle constants.
  - typedef zone_acc_t {xmin, xmax, ymin, ymax, cnt}.
- Sub-module zone_index: combinational x, y → {valid, k[3:0]}. It is instanced in stage 1 and unit-tested separately.

## Test plan
- Single red pixel at (200,130), MIN_PIXELS=1:
  - Zone 5 is detected with box 200/200/130/130 and aim (200,130).
  - All other flags are 0.
  - frame_update pulses once, 3 cycles after pixel (639,479).
- Red rectangle x 10..29, y 20..39 (400 px):
  - Zone 0 box is 10/29/20/39 and aim is (19,29).
  - A second frame with no red clears the flag but leaves the box values held.
- 63 red pixels in zone 15 with MIN_PIXELS=64 → not detected. With 64 pixels → detected, aim computed correctly.
- Red pixels on zone boundaries (159,0), (160,0), (0,119), (0,120) → land in zones 0, 1, 0 and 4 respectively.
- Samples with x=700, or with pix_valid=0 and is_red=1 → no effect on any zone.
- Assert reset_n mid-frame after 100 red pixels in zone 3, release, then send 5 red pixels with MIN_PIXELS=1 → the publish reflects only the 5 post-reset pixels.
